// File: rtl/conv_out_serializer.sv
// Serializes LANES-wide conv-stage beats into a ReLU-applied word stream,
// framing every FRAME_WORDS transferred words with o_tlast and o_frame_done.
module conv_out_serializer #(
  parameter int WORD_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int FRAME_WORDS = 32
) (
  input  logic                        i_aclk,
  input  logic                        i_areset,
  input  logic                        i_tvalid,
  output logic                        o_tready,
  input  logic [LANES*WORD_WIDTH-1:0] i_tdata,
  input  logic                        i_tready,
  output logic                        o_tvalid,
  output logic [WORD_WIDTH-1:0]       o_tdata,
  output logic                        o_tlast,
  output logic                        o_frame_done
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_WORDS - 1);

  if (LANES < 1 || FRAME_WORDS < 1 || (FRAME_WORDS % LANES) != 0) begin : g_bad_params
    $error("conv_out_serializer: FRAME_WORDS must be a nonzero multiple of LANES >= 1");
  end

  logic [LANES-1:0][WORD_WIDTH-1:0] hold_q;
  logic                             hold_valid_q;
  logic [LANE_W-1:0]                lane_q;
  logic [CNT_W-1:0]                 count_q;
  logic                             frame_done_q;

  logic                  xfer;
  logic                  last_lane;
  logic                  accept;
  logic [WORD_WIDTH-1:0] cur_word;

  assign o_tvalid  = hold_valid_q;
  assign xfer      = hold_valid_q && i_tready;
  assign last_lane = (lane_q == LAST_LANE);
  // A new beat may land in the same cycle the last held lane leaves.
  assign o_tready  = !hold_valid_q || (xfer && last_lane);
  assign accept    = i_tvalid && o_tready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cur_word = hold_q[lane_q];
    o_tdata  = '0;
    if (hold_valid_q && !cur_word[WORD_WIDTH-1]) begin
      o_tdata = cur_word;
    end
  end

  assign o_tlast      = hold_valid_q && (count_q == LAST_WORD);
  assign o_frame_done = frame_done_q;

  // NOTE: the data hold register carries no reset; hold_valid_q gates every use of it.
  always_ff @(posedge i_aclk) begin
    if (accept) begin
      hold_q <= i_tdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      hold_valid_q <= 1'b0;
      lane_q       <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= xfer && o_tlast;
      if (xfer) begin
        lane_q  <= last_lane ? '0 : lane_q + LANE_W'(1);
        count_q <= (count_q == LAST_WORD) ? '0 : count_q + CNT_W'(1);
      end
      if (accept) begin
        hold_valid_q <= 1'b1;
      end else if (xfer && last_lane) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_out_serializer.sv
// Directed bench for conv_out_serializer: expected words are queued when a beat is
// accepted and compared as each word transfers; framing and stalls are checked on the side.
module tb_conv_out_serializer;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int FW = 32;

  logic           i_aclk = 1'b0;
  logic           i_areset = 1'b1;
  logic           i_tvalid = 1'b0;
  logic           o_tready;
  logic [L*W-1:0] i_tdata = '0;
  logic           i_tready = 1'b0;
  logic           o_tvalid;
  logic [W-1:0]   o_tdata;
  logic           o_tlast;
  logic           o_frame_done;

  conv_out_serializer #(.WORD_WIDTH(W), .LANES(L), .FRAME_WORDS(FW)) dut (
    .i_aclk      (i_aclk),
    .i_areset    (i_areset),
    .i_tvalid    (i_tvalid),
    .o_tready    (o_tready),
    .i_tdata     (i_tdata),
    .i_tready    (i_tready),
    .o_tvalid    (o_tvalid),
    .o_tdata     (o_tdata),
    .o_tlast     (o_tlast),
    .o_frame_done(o_frame_done)
  );

  always #5 i_aclk = ~i_aclk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   tb_count = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   xfer_count = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  int   tlast_count = 0;
  int   fd_count = 0;
  logic fd_exp = 1'b0;
  logic stall_prev = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] w);
    return w[W-1] ? '0 : w;
  endfunction

  // Output monitor: scoreboard pop on transfer, stall stability, frame_done timing.
  always @(negedge i_aclk) begin
    cyc++;
    if (mon_en) begin
      check("frame_done", o_frame_done, fd_exp);
      if (o_frame_done) fd_count++;
      if (stall_prev && o_tvalid) begin
        check("stall_data", o_tdata, prev_data);
        check("stall_last", o_tlast, prev_last);
      end
      if (o_tvalid && i_tready && !i_areset) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("word_data", o_tdata, e.data);
          check("word_last", o_tlast, e.last);
        end
        xfer_count++;
        if (xfer_count == 1) first_cyc = cyc;
        last_cyc = cyc;
        if (o_tlast) tlast_count++;
      end
      fd_exp     = o_tvalid && i_tready && o_tlast && !i_areset;
      stall_prev = o_tvalid && !i_tready && !i_areset;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
    end
  end

  task automatic reset_dut();
    @(posedge i_aclk);
    #1;
    i_areset = 1'b1;
    i_tvalid = 1'b0;
    sb.delete();
    tb_count = 0;
    repeat (2) @(posedge i_aclk);
    #1;
    i_areset = 1'b0;
    @(negedge i_aclk);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_tready", o_tready, 1);
    mon_en = 1'b1;
    @(posedge i_aclk);
    #1;
  endtask

  // Present a beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [L*W-1:0] d);
    bit ok;
    ok = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = d;
    for (int t = 0; t < 100; t++) begin
      @(negedge i_aclk);
      if (o_tready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", ok, 1);
    @(posedge i_aclk);
    for (int k = 0; k < L; k++) begin
      sb.push_back({relu(d[k*W +: W]), tb_count == FW - 1});
      tb_count = (tb_count + 1) % FW;
    end
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge i_aclk);
      if (sb.size() == 0) break;
    end
    repeat (3) @(negedge i_aclk);
    check("drain_empty", sb.size(), 0);
    @(posedge i_aclk);
    #1;
  endtask

  task automatic clear_counters();
    xfer_count  = 0;
    tlast_count = 0;
    fd_count    = 0;
  endtask

  initial begin
    i_areset = 1'b1;
    repeat (3) @(posedge i_aclk);
    reset_dut();

    // Single beat: words in lane order, o_tready low while lanes 0..2 are held.
    i_tready = 1'b1;
    clear_counters();
    send_beat(32'h04_03_02_01);
    i_tvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_aclk);
      check("hold_tready_low", o_tready, 0);
    end
    @(negedge i_aclk);
    check("last_lane_tready", o_tready, 1);
    @(negedge i_aclk);
    check("empty_after_beat", o_tvalid, 0);
    drain();
    check("single_count", xfer_count, 4);
    check("single_span", last_cyc - first_cyc, 3);

    // ReLU on negative lanes.
    send_beat(32'h80_FF_7F_00);
    i_tvalid = 1'b0;
    drain();

    // Two full frames back to back.
    reset_dut();
    clear_counters();
    for (int b = 0; b < 16; b++) begin
      send_beat($urandom);
    end
    i_tvalid = 1'b0;
    drain();
    check("b2b_count", xfer_count, 64);
    check("b2b_span", last_cyc - first_cyc, 63);
    check("b2b_tlast", tlast_count, 2);
    check("b2b_frame_done", fd_count, 2);

    // Downstream stall while lane 2 is presented.
    clear_counters();
    send_beat(32'h44_33_22_11);
    i_tvalid = 1'b0;
    begin
      logic pat [6];
      pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
        i_tready = pat[i];
        @(posedge i_aclk);
        #1;
      end
    end
    i_tready = 1'b1;
    drain();
    check("stall_count", xfer_count, 4);

    // Reset after two words of a beat; next frame restarts at count 0.
    send_beat(32'h55_66_77_08);
    i_tvalid = 1'b0;
    @(posedge i_aclk);
    #1;
    @(posedge i_aclk);
    #1;
    i_areset = 1'b1;
    sb.delete();
    tb_count = 0;
    @(posedge i_aclk);
    #1;
    i_areset = 1'b0;
    @(negedge i_aclk);
    check("midrst_tvalid", o_tvalid, 0);
    check("midrst_tready", o_tready, 1);
    @(posedge i_aclk);
    #1;
    clear_counters();
    for (int b = 0; b < 8; b++) begin
      send_beat($urandom);
    end
    i_tvalid = 1'b0;
    drain();
    check("post_rst_count", xfer_count, 32);
    check("post_rst_tlast", tlast_count, 1);
    check("post_rst_frame_done", fd_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
